// File: rtl/spi_arb_pkg.sv
// Shared encodings for the SPI bus arbiter family.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_e;

  localparam logic CS_INACTIVE = 1'b1;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Request/grant handshake plus per-requester SPI lines and the shared output bus.
interface spi_bus_arbiter_if;
  logic REQ0, REQ1;
  logic CS0, CLK0, MOSI0;
  logic CS1, CLK1, MOSI1;
  logic GNT0, GNT1;
  logic SEL_AKTIV, BUSY, TIMEOUT_EVT;
  logic CS_OUT, CLK_OUT, MOSI_OUT;

  modport master (
    output REQ0, REQ1, CS0, CLK0, MOSI0, CS1, CLK1, MOSI1,
    input  GNT0, GNT1, SEL_AKTIV, BUSY, TIMEOUT_EVT, CS_OUT, CLK_OUT, MOSI_OUT
  );

  modport slave (
    input  REQ0, REQ1, CS0, CLK0, MOSI0, CS1, CLK1, MOSI1,
    output GNT0, GNT1, SEL_AKTIV, BUSY, TIMEOUT_EVT, CS_OUT, CLK_OUT, MOSI_OUT
  );
endinterface

// File: rtl/sel_tick_sync.sv
// Synchronises the asynchronous 1 kHz timebase and emits a one-cycle pulse per rising edge.
module sel_tick_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLK_1kHz,
  output logic TICK
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= CLK_1kHz;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign TICK = sync2_q & ~prev_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI bus between two masters, with guard time and idle timeout.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned         CNT_W           = 16,
  parameter logic [CNT_W-1:0]    GUARD_MS        = 16'd2,
  parameter logic [CNT_W-1:0]    IDLE_TIMEOUT_MS = 16'd100
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLK_1kHz,
  spi_bus_arbiter_if.slave  bus
);

  logic tick;

  sel_tick_sync u_tick_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLK_1kHz (CLK_1kHz),
    .TICK     (tick)
  );

  arb_state_e       state_q;
  logic             gnt0_q, gnt1_q, sel_q, last_q, tevt_q;
  logic             cs_q, sclk_q, mosi_q;
  logic [CNT_W-1:0] idle_cnt_q, guard_cnt_q;

  logic own_cs, own_clk, own_mosi, own_req, oth_req;
  logic release_c, timeout_c;

  // Signals of whichever requester currently owns the bus.
  always_comb begin
    own_cs   = bus.CS0;
    own_clk  = bus.CLK0;
    own_mosi = bus.MOSI0;
    own_req  = bus.REQ0;
    oth_req  = bus.REQ1;
    if (state_q == ST_OWN1) begin
      own_cs   = bus.CS1;
      own_clk  = bus.CLK1;
      own_mosi = bus.MOSI1;
      own_req  = bus.REQ1;
      oth_req  = bus.REQ0;
    end
  end

  assign release_c = !own_req && own_cs;
  assign timeout_c = (IDLE_TIMEOUT_MS != '0) && (idle_cnt_q >= IDLE_TIMEOUT_MS) && own_cs;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      tevt_q      <= 1'b0;
      cs_q        <= CS_INACTIVE;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      idle_cnt_q  <= '0;
      guard_cnt_q <= '0;
    end else begin
      tevt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cs_q       <= CS_INACTIVE;
          sclk_q     <= 1'b0;
          mosi_q     <= 1'b0;
          idle_cnt_q <= '0;
          // On a tie, the requester that did not own the bus last wins.
          if (bus.REQ0 && (!bus.REQ1 || last_q)) begin
            state_q <= ST_OWN0;
            gnt0_q  <= 1'b1;
            sel_q   <= 1'b0;
          end else if (bus.REQ1) begin
            state_q <= ST_OWN1;
            gnt1_q  <= 1'b1;
            sel_q   <= 1'b1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (release_c || timeout_c) begin
            state_q     <= ST_GUARD;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            last_q      <= (state_q == ST_OWN1);
            guard_cnt_q <= '0;
            tevt_q      <= !release_c;
            cs_q        <= CS_INACTIVE;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
          end else begin
            cs_q   <= own_cs;
            sclk_q <= own_clk;
            mosi_q <= own_mosi;
            if (!own_cs || !oth_req) begin
              idle_cnt_q <= '0;
            end else if (tick && (idle_cnt_q != '1)) begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        ST_GUARD: begin
          cs_q   <= CS_INACTIVE;
          sclk_q <= 1'b0;
          mosi_q <= 1'b0;
          if (guard_cnt_q == GUARD_MS) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            guard_cnt_q <= guard_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.GNT0        = gnt0_q;
  assign bus.GNT1        = gnt1_q;
  assign bus.SEL_AKTIV   = sel_q;
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.TIMEOUT_EVT = tevt_q;
  assign bus.CS_OUT      = cs_q;
  assign bus.CLK_OUT     = sclk_q;
  assign bus.MOSI_OUT    = mosi_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench: two arbiter instances (guard 2 ticks and guard 0) driven through shared clocks.
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_1k = 1'b0;
  int   total = 0;
  int   bad   = 0;

  spi_bus_arbiter_if bus_a ();
  spi_bus_arbiter_if bus_b ();

  spi_bus_arbiter #(
    .CNT_W           (16),
    .GUARD_MS        (16'd2),
    .IDLE_TIMEOUT_MS (16'd100)
  ) u_dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CLK_1kHz (clk_1k),
    .bus      (bus_a)
  );

  spi_bus_arbiter #(
    .CNT_W           (16),
    .GUARD_MS        (16'd0),
    .IDLE_TIMEOUT_MS (16'd100)
  ) u_dut_g0 (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CLK_1kHz (clk_1k),
    .bus      (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One synchronised tick is consumed by the third edge; the fourth edge sees its effect.
  task automatic tick_pulse();
    clk_1k = 1'b1;
    step(2);
    clk_1k = 1'b0;
    step(2);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_pulse();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("mutex_a", bus_a.GNT0 & bus_a.GNT1, 1'b0);
      chk("mutex_b", bus_b.GNT0 & bus_b.GNT1, 1'b0);
      chk("cs_low_no_owner_a", !bus_a.CS_OUT && !(bus_a.GNT0 | bus_a.GNT1), 1'b0);
      chk("cs_low_no_owner_b", !bus_b.CS_OUT && !(bus_b.GNT0 | bus_b.GNT1), 1'b0);
    end
  end

  initial begin
    {bus_a.REQ0, bus_a.REQ1, bus_a.CLK0, bus_a.MOSI0, bus_a.CLK1, bus_a.MOSI1} = '0;
    {bus_b.REQ0, bus_b.REQ1, bus_b.CLK0, bus_b.MOSI0, bus_b.CLK1, bus_b.MOSI1} = '0;
    bus_a.CS0 = 1'b1; bus_a.CS1 = 1'b1;
    bus_b.CS0 = 1'b1; bus_b.CS1 = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_gnt0", bus_a.GNT0, 1'b0);
    chk("rst_gnt1", bus_a.GNT1, 1'b0);
    chk("rst_sel", bus_a.SEL_AKTIV, 1'b0);
    chk("rst_busy", bus_a.BUSY, 1'b0);
    chk("rst_tevt", bus_a.TIMEOUT_EVT, 1'b0);
    chk("rst_cs", bus_a.CS_OUT, 1'b1);
    chk("rst_clk", bus_a.CLK_OUT, 1'b0);
    chk("rst_mosi", bus_a.MOSI_OUT, 1'b0);
    rst_n = 1'b1;
    step(1);

    // Tie after reset: requester 0 wins.
    bus_a.REQ0 = 1'b1; bus_a.REQ1 = 1'b1;
    step(1);
    chk("tie_gnt0", bus_a.GNT0, 1'b1);
    chk("tie_gnt1", bus_a.GNT1, 1'b0);
    chk("tie_sel", bus_a.SEL_AKTIV, 1'b0);
    chk("tie_busy", bus_a.BUSY, 1'b1);
    bus_a.CS0 = 1'b0; bus_a.CLK0 = 1'b1; bus_a.MOSI0 = 1'b1;
    step(1);
    chk("dp_cs", bus_a.CS_OUT, 1'b0);
    chk("dp_clk", bus_a.CLK_OUT, 1'b1);
    chk("dp_mosi", bus_a.MOSI_OUT, 1'b1);
    bus_a.CS0 = 1'b1; bus_a.CLK0 = 1'b0; bus_a.MOSI0 = 1'b0;
    step(1);
    chk("dp_cs_hi", bus_a.CS_OUT, 1'b1);
    chk("dp_clk_lo", bus_a.CLK_OUT, 1'b0);
    bus_a.REQ0 = 1'b0;
    step(1);
    chk("guard_gnt0", bus_a.GNT0, 1'b0);
    chk("guard_busy", bus_a.BUSY, 1'b1);
    chk("guard_sel", bus_a.SEL_AKTIV, 1'b0);
    tick_pulse();
    chk("guard1_gnt1", bus_a.GNT1, 1'b0);
    chk("guard1_busy", bus_a.BUSY, 1'b1);
    tick_pulse();
    chk("guard2_idle", bus_a.BUSY, 1'b0);
    chk("guard2_gnt1", bus_a.GNT1, 1'b0);
    step(1);
    chk("own1_gnt1", bus_a.GNT1, 1'b1);
    chk("own1_sel", bus_a.SEL_AKTIV, 1'b1);

    // Release requester 1 normally.
    bus_a.REQ1 = 1'b0;
    step(1);
    chk("rel1_gnt1", bus_a.GNT1, 1'b0);
    chk("rel1_sel_hold", bus_a.SEL_AKTIV, 1'b1);
    ticks(2);
    chk("rel1_idle", bus_a.BUSY, 1'b0);

    // No preemption while requester 0 holds CS low.
    bus_a.REQ0 = 1'b1;
    step(1);
    chk("np_gnt0", bus_a.GNT0, 1'b1);
    bus_a.CS0 = 1'b0;
    step(1);
    chk("np_cs", bus_a.CS_OUT, 1'b0);
    bus_a.REQ0 = 1'b0; bus_a.REQ1 = 1'b1;
    ticks(50);
    chk("np_gnt0_hold", bus_a.GNT0, 1'b1);
    chk("np_gnt1_wait", bus_a.GNT1, 1'b0);
    chk("np_cs_hold", bus_a.CS_OUT, 1'b0);
    chk("np_no_tevt", bus_a.TIMEOUT_EVT, 1'b0);
    bus_a.MOSI0 = 1'b1;
    step(1);
    chk("np_mosi", bus_a.MOSI_OUT, 1'b1);
    bus_a.CS0 = 1'b1; bus_a.MOSI0 = 1'b0;
    step(1);
    chk("np_release", bus_a.GNT0, 1'b0);
    chk("np_rel_cs", bus_a.CS_OUT, 1'b1);
    chk("np_rel_mosi", bus_a.MOSI_OUT, 1'b0);
    chk("np_rel_tevt", bus_a.TIMEOUT_EVT, 1'b0);
    ticks(2);
    step(1);
    chk("np_gnt1", bus_a.GNT1, 1'b1);
    bus_a.REQ1 = 1'b0;
    step(1);
    ticks(2);
    chk("np_idle", bus_a.BUSY, 1'b0);

    // Idle timeout with a restart by a CS0 low pulse after 60 ticks.
    bus_a.REQ0 = 1'b1; bus_a.REQ1 = 1'b1;
    step(1);
    chk("to_gnt0", bus_a.GNT0, 1'b1);
    ticks(60);
    chk("to60_gnt0", bus_a.GNT0, 1'b1);
    bus_a.CS0 = 1'b0;
    step(1);
    bus_a.CS0 = 1'b1;
    step(1);
    ticks(99);
    chk("to99_gnt0", bus_a.GNT0, 1'b1);
    chk("to99_tevt", bus_a.TIMEOUT_EVT, 1'b0);
    tick_pulse();
    chk("to100_tevt", bus_a.TIMEOUT_EVT, 1'b1);
    chk("to100_gnt0", bus_a.GNT0, 1'b0);
    chk("to100_busy", bus_a.BUSY, 1'b1);
    step(1);
    chk("to_tevt_pulse", bus_a.TIMEOUT_EVT, 1'b0);
    ticks(2);
    step(1);
    chk("to_gnt1", bus_a.GNT1, 1'b1);
    chk("to_gnt0_lost", bus_a.GNT0, 1'b0);
    chk("to_sel", bus_a.SEL_AKTIV, 1'b1);

    // Asynchronous reset mid-transfer of requester 1.
    bus_a.CS1 = 1'b0;
    step(1);
    chk("pre_rst_cs", bus_a.CS_OUT, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", bus_a.CS_OUT, 1'b1);
    chk("arst_gnt1", bus_a.GNT1, 1'b0);
    chk("arst_busy", bus_a.BUSY, 1'b0);
    chk("arst_sel", bus_a.SEL_AKTIV, 1'b0);
    {bus_a.REQ0, bus_a.REQ1} = 2'b00;
    bus_a.CS1 = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);

    // Zero guard time: exactly one GUARD cycle, then IDLE, then the other owner.
    bus_b.REQ0 = 1'b1; bus_b.REQ1 = 1'b1;
    step(1);
    chk("g0_gnt0", bus_b.GNT0, 1'b1);
    chk("g0_sel0", bus_b.SEL_AKTIV, 1'b0);
    bus_b.REQ0 = 1'b0;
    step(1);
    chk("g0_guard_gnt0", bus_b.GNT0, 1'b0);
    chk("g0_guard_busy", bus_b.BUSY, 1'b1);
    chk("g0_guard_gnt1", bus_b.GNT1, 1'b0);
    step(1);
    chk("g0_idle_busy", bus_b.BUSY, 1'b0);
    chk("g0_idle_gnt1", bus_b.GNT1, 1'b0);
    step(1);
    chk("g0_gnt1", bus_b.GNT1, 1'b1);
    chk("g0_sel1", bus_b.SEL_AKTIV, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
Arbitrates one shared SPI output bus between two SPI masters, requester 0 and requester 1. It grants the bus through a REQ/GNT handshake and uses round-robin on simultaneous requests. It never switches owners mid-transaction and inserts a guard time, counted in 1 kHz ticks, with CS held inactive between owners. It drives the registered muxed bus and SEL_AKTIV for downstream select logic, and sits between the SPI master blocks and the external SPI pins.

Parameters:
GUARD_MS, 16'd2, 1 kHz ticks of forced-idle bus between owners
IDLE_TIMEOUT_MS, 16'd100, ticks an owner may keep its grant with CS idle while the other requester waits
CNT_W, 16, tick counter width

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CLK_1kHz  in  1  asynchronous 1 kHz timebase
REQ0, REQ1  in  1 each  bus request from requester 0/1 (level)
CS0, CLK0, MOSI0  in  1 each  SPI signals of requester 0 (CS active-low)
CS1, CLK1, MOSI1  in  1 each  SPI signals of requester 1
GNT0, GNT1  out  1 each  grant to requester 0/1 (registered)
SEL_AKTIV  out  1  current/last owner: 0 = requester 0, 1 = requester 1
BUSY  out  1  state != IDLE
TIMEOUT_EVT  out  1  one-cycle pulse on forced release
CS_OUT, CLK_OUT, MOSI_OUT  out  1 each  shared SPI bus

Behaviour:
- Reset (RST_N low, async): state=IDLE, GNT0=GNT1=0, SEL_AKTIV=0, BUSY=0, TIMEOUT_EVT=0, CS_OUT=1, CLK_OUT=0, MOSI_OUT=0, counters=0, last_owner=1 (so requester 0 wins the first tie). Reset mid-transfer aborts immediately; no guard time is applied after reset.
- Tick: CLK_1kHz goes through a 2-FF synchronizer, then rising-edge detection; tick = one CLK-wide pulse.
- States: IDLE, OWN0, OWN1, GUARD.
- IDLE transitions:
  - REQ0&REQ1 -> OWNx, where x != last_owner.
  - Only REQ0 -> OWN0; only REQ1 -> OWN1.
  - GNTx and SEL_AKTIV=x update on the same edge that enters OWNx (grant latency: 1 cycle from REQ sampled high).
- OWNx datapath: CS_OUT/CLK_OUT/MOSI_OUT <= CSx/CLKx/MOSIx each cycle (1-cycle registered latency).
- OWNx normal release: REQx low AND CSx high -> GUARD. If CSx is low, the grant holds even if REQx has dropped; the owner must finish its frame.
- OWNx timeout:
  - idle_cnt clears whenever CSx is low or the other REQ is low.
  - Otherwise idle_cnt increments on each tick, saturating at 2^CNT_W-1.
  - idle_cnt >= IDLE_TIMEOUT_MS with CSx high -> GUARD, TIMEOUT_EVT pulses for 1 cycle.
  - IDLE_TIMEOUT_MS=0 disables the timeout.
- Entering GUARD: GNTx<=0, last_owner<=x, guard_cnt<=0.
- GUARD outputs: CS_OUT=1, CLK_OUT=0, MOSI_OUT=0; SEL_AKTIV holds the last owner.
- GUARD timing: guard_cnt increments on tick; exits to IDLE on the cycle guard_cnt reaches GUARD_MS. GUARD_MS=0 means exactly one cycle in GUARD. Requests are ignored during GUARD.
- Timeout return: a requester released by timeout that still holds REQ re-competes in IDLE and loses the tie by round-robin.
- Simultaneous events:
  - Release condition and timeout in the same cycle -> counted as a normal release, no TIMEOUT_EVT.
  - Tick and CSx falling edge in the same cycle -> idle_cnt clears.
- Invariants: GNT0&GNT1 never both 1; CS_OUT never low outside OWN0/OWN1.

Decomposition:
- Shared package spi_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2, ST_GUARD=2'd3
  - CS_INACTIVE=1'b1
- One sub-module, sel_tick_sync: 2-FF synchronizer plus rising-edge detector for CLK_1kHz, ports CLK, RST_N, CLK_1kHz, TICK. It is reusable by other SEL-family blocks.

Test Plan:
- Reset: RST_N low mid-OWN1 with CS1=0 -> same-cycle async clear: CS_OUT=1, GNT1=0, BUSY=0, SEL_AKTIV=0.
- Tie: REQ0=REQ1=1 after reset -> GNT0=1 next cycle, SEL_AKTIV=0. Then requester 0 drops REQ0 with CS0=1 -> GUARD with CS_OUT=1 for 2 ticks -> GNT1=1, SEL_AKTIV=1.
- No preemption: in OWN0, CS0=0 for 50 ms while REQ0 drops and REQ1=1 -> GNT0 stays 1, bus follows requester 0 with 1-cycle latency. Release occurs 1 cycle after CS0 returns high.
- Timeout: in OWN0, REQ0=1, CS0=1, REQ1=1 for 100 ticks -> TIMEOUT_EVT single pulse, GUARD, then GNT1. A CS0 low pulse at tick 60 restarts the count, so release happens 100 ticks after CS0 rises.
- Guard boundary: GUARD_MS=0 instance -> exactly one GUARD cycle between GNT0 fall and GNT1 rise. Throughout all scenarios, assert GNT0&GNT1 never both 1.
